// File: rtl/mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory-side responder for the multicycle MIPS datapath. Accepts
//             one word read or write request at a time, spends a fixed number
//             of wait states, performs the access on an internal word array
//             and returns the result with a one-cycle ready pulse.
//  Ports    : clk        - single clock, rising edge
//             rst_n      - asynchronous active-low reset
//             req_addr   - word address (full 32 bits compared, no aliasing)
//             req_wdata  - write data
//             req_read   - read request level
//             req_write  - write request level
//             rsp_rdata  - read/write-echo data, held until the next response
//             rsp_ready  - one-cycle completion pulse
//             rsp_err    - error flag, meaningful while rsp_ready is high
//             busy       - high whenever the FSM is outside IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int          ADDR_WORDS  = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] INIT_WORD   = 32'h000000BD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_read,
  input  logic        req_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_ready,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          IDX_W      = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        read_q;
  logic        write_q;
  logic        do_access;
  logic        access_ok;
  logic [IDX_W-1:0] idx;

  // Array starts at INIT_WORD at time zero and is never touched by reset.
  logic [31:0] mem [ADDR_WORDS] = '{default: INIT_WORD};

  // A simultaneous read+write request is an error, as is any address at or
  // beyond the array size; the comparison uses the whole 32-bit address.
  assign access_ok = (addr_q < ADDR_LIMIT) && !(read_q && write_q);
  assign idx       = addr_q[IDX_W-1:0];
  assign busy      = (state != IDLE);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state; do_access marks the WAIT->ACK edge
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (req_read || req_write) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, wait counter and registered response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_ready <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && (req_read || req_write)) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        read_q  <= req_read;
        write_q <= req_write;
        cnt     <= WAIT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      rsp_ready <= do_access;

      if (do_access) begin
        if (access_ok) begin
          rsp_rdata <= write_q ? wdata_q : mem[idx];
          rsp_err   <= 1'b0;
        end else begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b1;
        end
      end else if (state == ACK) begin
        // Error flag only lives for the ACK cycle; data is held.
        rsp_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Array write. Kept out of the reset block so reset never alters contents;
  // a write in flight when reset hits is lost because the FSM leaves WAIT.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && do_access && access_ok && write_q) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder. Three instances with
//             WAIT_STATES of 2, 0 and 5 share clock and reset; each is
//             compared against a word-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int          N    = 3;
  localparam int          AW   = 256;
  localparam logic [31:0] INIT = 32'h000000BD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic        req_read  [N];
  logic        req_write [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_ready [N];
  logic        rsp_err   [N];
  logic        busy      [N];

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [N][AW];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WORDS(AW), .WAIT_STATES(2), .INIT_WORD(INIT)) u_ws2 (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_read(req_read[0]), .req_write(req_write[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_ready(rsp_ready[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mem_responder #(.ADDR_WORDS(AW), .WAIT_STATES(0), .INIT_WORD(INIT)) u_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_read(req_read[1]), .req_write(req_write[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_ready(rsp_ready[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  mem_responder #(.ADDR_WORDS(AW), .WAIT_STATES(5), .INIT_WORD(INIT)) u_ws5 (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_read(req_read[2]), .req_write(req_write[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_ready(rsp_ready[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2])
  );

  function automatic int ws_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k, checked against the model.
  task automatic txn(input int k, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    if ((rd && wr) || a >= 32'(AW)) begin
      exp_d = 32'd0;
      exp_e = 1'b1;
    end else if (wr) begin
      model[k][a[7:0]] = d;
      exp_d = d;
      exp_e = 1'b0;
    end else begin
      exp_d = model[k][a[7:0]];
      exp_e = 1'b0;
    end
    @(negedge clk);
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_read[k]  = rd;
    req_write[k] = wr;
    @(posedge clk);
    #1;
    chk($sformatf("%s_busy_rise", tag), 32'(busy[k]), 32'd1);
    @(negedge clk);
    req_read[k]  = 1'b0;
    req_write[k] = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_ready[k]) break;
    end
    chk($sformatf("%s_latency", tag), 32'(n), 32'(ws_of(k) + 1));
    chk($sformatf("%s_rdata", tag), rsp_rdata[k], exp_d);
    chk($sformatf("%s_err", tag), 32'(rsp_err[k]), 32'(exp_e));
    @(posedge clk);
    #1;
    chk($sformatf("%s_ready_fall", tag), 32'(rsp_ready[k]), 32'd0);
    chk($sformatf("%s_busy_fall", tag), 32'(busy[k]), 32'd0);
    chk($sformatf("%s_err_clear", tag), 32'(rsp_err[k]), 32'd0);
    chk($sformatf("%s_rdata_hold", tag), rsp_rdata[k], exp_d);
  endtask

  initial begin
    int pulses;
    int cyc;
    int got;
    int times [3];
    logic [31:0] a;
    logic [31:0] d;
    int r;
    int o;

    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < AW; w++) model[k][w] = INIT;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      req_read[k]  = 1'b0;
      req_write[k] = 1'b0;
    end

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst%0d_ready", k), 32'(rsp_ready[k]), 32'd0);
      chk($sformatf("rst%0d_err", k), 32'(rsp_err[k]), 32'd0);
      chk($sformatf("rst%0d_rdata", k), rsp_rdata[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence on the WAIT_STATES=2 instance
    txn(0, 1'b1, 1'b0, 32'd5,   32'd0,          "rd5_init");
    txn(0, 1'b0, 1'b1, 32'd10,  32'hDEADBEEF,   "wr10");
    txn(0, 1'b1, 1'b0, 32'd10,  32'd0,          "rd10");
    txn(0, 1'b1, 1'b0, 32'd11,  32'd0,          "rd11");
    txn(0, 1'b0, 1'b1, 32'd256, 32'h00001234,   "wr256");
    txn(0, 1'b1, 1'b0, 32'd256, 32'd0,          "rd256");
    txn(0, 1'b1, 1'b0, 32'd0,   32'd0,          "rd0");
    txn(0, 1'b1, 1'b1, 32'd3,   32'h00000055,   "rdwr3");
    txn(0, 1'b1, 1'b0, 32'd3,   32'd0,          "rd3");

    // Reset in the middle of a write: nothing lands, no ready pulse
    @(negedge clk);
    req_addr[0]  = 32'd7;
    req_wdata[0] = 32'h000000AA;
    req_write[0] = 1'b1;
    @(posedge clk);
    #1;
    req_write[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_ready", 32'(rsp_ready[0]), 32'd0);
    chk("midrst_err", 32'(rsp_err[0]), 32'd0);
    chk("midrst_rdata", rsp_rdata[0], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rsp_ready[0]) pulses++;
    end
    chk("midrst_no_ready", 32'(pulses), 32'd0);
    txn(0, 1'b1, 1'b0, 32'd7, 32'd0, "rd7_after_rst");

    // Held request: back-to-back spacing and latency on every instance
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 3; t++) times[t] = 0;
      @(negedge clk);
      req_addr[k] = 32'd5;
      req_read[k] = 1'b1;
      cyc = 0;
      got = 0;
      while (got < 3 && cyc < 200) begin
        @(posedge clk);
        cyc++;
        #1;
        if (rsp_ready[k]) begin
          times[got] = cyc;
          chk($sformatf("held%0d_rdata%0d", k, got), rsp_rdata[k], model[k][5]);
          got++;
        end
      end
      @(negedge clk);
      req_read[k] = 1'b0;
      chk($sformatf("held%0d_latency", k), 32'(times[0] - 1), 32'(ws_of(k) + 1));
      chk($sformatf("held%0d_space1", k), 32'(times[1] - times[0]), 32'(ws_of(k) + 3));
      chk($sformatf("held%0d_space2", k), 32'(times[2] - times[1]), 32'(ws_of(k) + 3));
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("held%0d_idle", k), 32'(busy[k]), 32'd0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 25; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      a = 32'($urandom_range(0, 15));
        else if (r < 8) a = 32'($urandom_range(250, 262));
        else            a = 32'h80000000 | 32'($urandom_range(0, 15));
        d = $urandom;
        o = $urandom_range(0, 6);
        if (o < 3)      txn(k, 1'b1, 1'b0, a, d, $sformatf("rnd%0d_%0d_rd", k, i));
        else if (o < 6) txn(k, 1'b0, 1'b1, a, d, $sformatf("rnd%0d_%0d_wr", k, i));
        else            txn(k, 1'b1, 1'b1, a, d, $sformatf("rnd%0d_%0d_both", k, i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
